seu_chain_checker: RTL

Pattern source and checker for a serial flop chain under radiation test. Drives a PRBS7 stream into the chain's serial input, regenerates the same stream delayed by the chain latency, compares it bit-for-bit with the chain's serial output, and counts mismatches as single-event upsets. Sits beside each shift chain in the user logic; its error count feeds the monitor's readout.

---
 rtl/seu_chain_pkg.sv | 12 +
 rtl/prbs7_lfsr.sv | 22 ++
 rtl/seu_chain_checker.sv | 67 ++++++
 3 files changed

// File: rtl/seu_chain_pkg.sv
// seu_chain_pkg: PRBS7 constants and checker state encoding shared by the
// chain checker and its pattern generators.
package seu_chain_pkg;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2
    } state_t;
endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: x^7+x^6+1 generator; load reseeds and takes priority over step.
module prbs7_lfsr
    import seu_chain_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic bit_out
);
    logic [6:0] lfsr;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            lfsr <= PRBS7_SEED;
        else if (load)
            lfsr <= PRBS7_SEED;
        else if (step)
            lfsr <= {lfsr[5:0], lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO]};

    assign bit_out = lfsr[6];
endmodule

// File: rtl/seu_chain_checker.sv
// seu_chain_checker: drives PRBS7 into a serial chain and counts upsets by
// comparing the chain output against a copy of the stream delayed by LATENCY.
module seu_chain_checker
    import seu_chain_pkg::*;
#(
    parameter int LATENCY = 17,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear_count,
    input  logic             chain_q,
    output logic             chain_d,
    output logic             checking,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count
);
    localparam int PW = $clog2(LATENCY + 1);
    localparam logic [PW-1:0] LAST = PW'(LATENCY - 1);

    state_t        state;
    logic [PW-1:0] cnt;
    logic          ref_bit;
    logic          load;
    logic          mismatch;

    assign load     = !enable || state == IDLE;
    assign mismatch = state == CHECK && chain_q != ref_bit;
    assign checking = state == CHECK;

    // ref stays parked on the seed until the first transmitted bit reaches chain_q
    prbs7_lfsr u_tx (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (state != IDLE),
        .bit_out(chain_d)
    );

    prbs7_lfsr u_ref (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (state == CHECK),
        .bit_out(ref_bit)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err_pulse <= 1'b0;
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= !enable ? IDLE :
                         state == IDLE ? PRIME :
                         (state == PRIME && cnt == LAST) ? CHECK : state;
            cnt       <= (state == PRIME && enable) ? cnt + 1'b1 : '0;
            err_pulse <= mismatch;
            err_flag  <= !clear_count && (err_flag || mismatch);
            err_count <= clear_count ? '0 :
                         (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;
        end
endmodule
